// File: rtl/dec_conv_if.sv
// Divider bus between dec_conv (master) and the iterative divider (slave).
// Carries the dividend/divisor request and the quotient/remainder reply.
interface dec_conv_if #(
    parameter int BITS = 32
);
    logic            start;
    logic [BITS-1:0] n;
    logic [BITS-1:0] d;
    logic [BITS-1:0] q;
    logic [BITS-1:0] r;
    logic            rdy;

    modport master (
        output start, n, d,
        input  q, r, rdy
    );

    modport slave (
        input  start, n, d,
        output q, r, rdy
    );
endinterface

// File: rtl/dec_conv.sv
// Binary to packed-BCD converter by repeated division by 10 on an external divider.
// Define DEC_CONV_SIGNED_EN to treat val as two's complement (sets neg, converts magnitude).
module dec_conv #(
    parameter int BITS   = 32,
    parameter int DIGITS = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BITS-1:0]              val,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [4*DIGITS-1:0]          bcd,
    output logic [$clog2(DIGITS+1)-1:0]  ndigits,
    output logic                         neg,
    dec_conv_if.master                   dv
);
    localparam int KW = $clog2(DIGITS+1);
    localparam logic [KW-1:0] KLAST = KW'(DIGITS-1);

    typedef enum logic [2:0] {
        IDLE, LOAD, KICK, WAIT, STORE, FIN
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [BITS-1:0]     work;
    logic [KW-1:0]       k;
    logic [4*DIGITS-1:0] bcd_q;
    logic                neg_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        dv.start = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = LOAD;
            end
            LOAD: state_nx = KICK;
            KICK: begin
                dv.start = 1'b1;
                state_nx = WAIT;
            end
            WAIT: if (dv.rdy) state_nx = STORE;
            // Last digit slot also ends the run so bcd can never overflow
            STORE: begin
                if (dv.q == '0 || k == KLAST) state_nx = FIN;
                else                          state_nx = KICK;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work  <= '0;
            k     <= '0;
            bcd_q <= '0;
            neg_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= val;
                        k     <= '0;
                        bcd_q <= '0;
                        neg_q <= 1'b0;
                    end
                end
                LOAD: begin
`ifdef DEC_CONV_SIGNED_EN
                    neg_q <= work[BITS-1];
                    if (work[BITS-1]) work <= ~work + 1'b1;
`else
                    neg_q <= 1'b0;
`endif
                end
                STORE: begin
                    bcd_q[{k, 2'b00} +: 4] <= dv.r[3:0];
                    work                   <= dv.q;
                    k                      <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dv.n    = work;
    assign dv.d    = BITS'(10);
    assign bcd     = bcd_q;
    assign ndigits = k;
    assign neg     = neg_q;
endmodule

// File: tb/tb_dec_conv.sv
// Randomized bench for dec_conv with a behavioural divider and a decimal reference model.
// Honours DEC_CONV_SIGNED_EN the same way the design does.
module tb_dec_conv;
    localparam int BITS   = 32;
    localparam int DIGITS = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] val = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [39:0] bcd;
    logic [3:0]  ndigits;
    logic        neg;

    int n_tests = 0;
    int n_fail  = 0;
    int n_kick  = 0;
    int n_done  = 0;
    int lat_cnt = 0;

    dec_conv_if #(.BITS(BITS)) dv ();

    dec_conv #(.BITS(BITS), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .val     (val),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd),
        .ndigits (ndigits),
        .neg     (neg),
        .dv      (dv)
    );

    always #5 clk = ~clk;

    // Divider model: rdy low on the start edge and the next, then random latency
    initial begin
        dv.q   = '0;
        dv.r   = '0;
        dv.rdy = 1'b1;
    end

    always @(posedge clk) begin
        if (dv.start) begin
            dv.rdy  <= 1'b0;
            dv.q    <= dv.n / dv.d;
            dv.r    <= dv.n % dv.d;
            lat_cnt <= $urandom_range(1, BITS + 1);
            n_kick  <= n_kick + 1;
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
        end else begin
            dv.rdy <= 1'b1;
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ref_model(input logic [31:0] v, output logic [39:0] eb,
                             output int nd, output logic ng);
        longint unsigned m;
        m  = v;
        ng = 1'b0;
`ifdef DEC_CONV_SIGNED_EN
        if (v[31]) begin
            ng = 1'b1;
            m  = 64'h1_0000_0000 - longint'(v);
        end
`endif
        eb = '0;
        nd = 0;
        do begin
            eb[nd*4 +: 4] = 4'(m % 10);
            m  = m / 10;
            nd++;
        end while (m != 0 && nd < DIGITS);
    endtask

    task automatic run(input logic [31:0] v, input string tag, input bit poke);
        logic [39:0] eb;
        int          nd;
        logic        ng;
        int          k0;
        int          d0;
        bit          seen;
        ref_model(v, eb, nd, ng);
        k0 = n_kick;
        d0 = n_done;
        @(negedge clk);
        val   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        val   = '0;
        check({tag, ".busy_on"}, 64'(busy), 64'd1);
        if (poke) begin
            repeat (3) @(negedge clk);
            val   = 32'd7;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, ".done_seen"}, 64'(seen), 64'd1);
        check({tag, ".bcd"}, 64'(bcd), 64'(eb));
        check({tag, ".ndigits"}, 64'(ndigits), 64'(nd));
        check({tag, ".neg"}, 64'(neg), 64'(ng));
        check({tag, ".kicks"}, 64'(n_kick - k0), 64'(nd));
        @(negedge clk);
        check({tag, ".done_pulse"}, 64'(done), 64'd0);
        check({tag, ".busy_off"}, 64'(busy), 64'd0);
        repeat (20) @(negedge clk);
        check({tag, ".one_done"}, 64'(n_done - d0), 64'd1);
        check({tag, ".hold"}, 64'(bcd), 64'(eb));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.bcd", 64'(bcd), 64'd0);
        check("rst.ndigits", 64'(ndigits), 64'd0);
        check("rst.neg", 64'(neg), 64'd0);
        check("rst.div_start", 64'(dv.start), 64'd0);
        check("rst.div_n", 64'(dv.n), 64'd0);
        check("div_d", 64'(dv.d), 64'd10);
        rst = 1'b0;

        run(32'd12345, "v12345", 1'b0);
        run(32'd0, "zero", 1'b0);
        run(32'hFFFF_FFFF, "allones", 1'b0);
        run(32'hFFFF_FF85, "m123", 1'b0);
        run(32'h8000_0000, "minneg", 1'b0);
        run(32'd9, "nine", 1'b0);
        run(32'd10, "ten", 1'b0);
        run(32'd12345, "busy_start", 1'b1);

        for (int i = 0; i < 16; i++)
            run($urandom >> $urandom_range(0, 31), $sformatf("rnd%0d", i), 1'b0);

        // Reset while the divider is still working
        @(negedge clk);
        val   = 32'd12345;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst.busy", 64'(busy), 64'd0);
        check("mid_rst.bcd", 64'(bcd), 64'd0);
        check("mid_rst.ndigits", 64'(ndigits), 64'd0);
        begin
            int d0;
            d0 = n_done;
            repeat (60) @(negedge clk);
            check("mid_rst.no_done", 64'(n_done - d0), 64'd0);
        end
        run(32'd42, "after_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
